input_queue: RTL and testbench

Per-port input buffer and route-decode stage placed directly upstream of the router arbiter. It accepts flits from a neighbouring router (or the local PE), stores them in a small FIFO, computes the destination-hit flags for the head flit, and presents the `{hit_x, hit_y, request}` request bundle the arbiter consumes. A grant pops the head flit, and a registered credit pulse returns buffer space to the upstream sender.

---
 rtl/atto_pkg.sv | 22 ++
 rtl/fifo_regfile.sv | 25 ++
 rtl/input_queue.sv | 89 ++++++++
 tb/tb_input_queue.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/atto_pkg.sv
// Definitions shared by the router input queue, arbiter and crossbar:
// flit field widths, request-bundle bit positions and crossbar mux codes.
package atto_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_X_WIDTH    = 3;
    localparam int DEF_Y_WIDTH    = 3;

    localparam int HIT_X = 2;
    localparam int HIT_Y = 1;
    localparam int REQ   = 0;

    localparam logic [1:0] MUX_WEST  = 2'd0;
    localparam logic [1:0] MUX_SOUTH = 2'd1;
    localparam logic [1:0] MUX_EJECT = 2'd2;
    localparam logic [1:0] MUX_NONE  = 2'd3;

    function automatic int flit_width(input int xw, input int yw, input int dw);
        return xw + yw + dw;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Flit storage: one synchronous write port, one asynchronous read port.
// The array has no reset; validity is tracked by the owner's pointers.
module fifo_regfile #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 38
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/input_queue.sv
// Router input port: flit FIFO, head-flit route decode into the arbiter
// request bundle, registered credit return and a sticky overflow flag.
module input_queue
    import atto_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int X_WIDTH    = DEF_X_WIDTH,
    parameter int Y_WIDTH    = DEF_Y_WIDTH,
    parameter int DEPTH      = 4,
    parameter int X_LOCAL    = 0,
    parameter int Y_LOCAL    = 0,
    localparam int FW        = flit_width(X_WIDTH, Y_WIDTH, DATA_WIDTH),
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [FW-1:0] in_flit,
    output logic          credit_out,
    input  logic          grant,
    output logic [2:0]    request_bundle,
    output logic [FW-1:0] head_flit,
    output logic [AW:0]   occupancy,
    output logic          overflow
);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_credit;
    logic          r_overflow;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [FW-1:0] w_rdata;
    logic [FW-1:0] w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = grant && !w_empty;
    // A pop frees the head slot this edge, so a full queue can still accept.
    assign w_push  = in_valid && (!w_full || w_pop);
    assign w_drop  = in_valid && w_full && !w_pop;

    fifo_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_regfile (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (in_flit),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_credit   <= w_pop;
            r_overflow <= r_overflow | w_drop;
        end
    end

    assign w_head = w_empty ? '0 : w_rdata;

    always_comb begin
        request_bundle        = '0;
        request_bundle[REQ]   = !w_empty;
        request_bundle[HIT_X] = !w_empty &&
            (w_head[FW-1 -: X_WIDTH] == X_WIDTH'(X_LOCAL));
        request_bundle[HIT_Y] = !w_empty &&
            (w_head[FW-X_WIDTH-1 -: Y_WIDTH] == Y_WIDTH'(Y_LOCAL));
    end

    assign head_flit  = w_head;
    assign occupancy  = r_wr_ptr - r_rd_ptr;
    assign credit_out = r_credit;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_input_queue.sv
// Self-checking bench for input_queue with X_LOCAL=2, Y_LOCAL=1, DEPTH=4.
module tb_input_queue;

    localparam int DW    = 32;
    localparam int XW    = 3;
    localparam int YW    = 3;
    localparam int DEPTH = 4;
    localparam int FW    = XW + YW + DW;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [FW-1:0] in_flit;
    logic          credit_out;
    logic          grant;
    logic [2:0]    request_bundle;
    logic [FW-1:0] head_flit;
    logic [2:0]    occupancy;
    logic          overflow;

    logic [FW-1:0] exp_q[$];
    logic          m_ovf;
    int            n_checks;
    int            n_errors;
    int            n_credits;

    input_queue #(
        .DATA_WIDTH (DW),
        .X_WIDTH    (XW),
        .Y_WIDTH    (YW),
        .DEPTH      (DEPTH),
        .X_LOCAL    (2),
        .Y_LOCAL    (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_flit        (in_flit),
        .credit_out     (credit_out),
        .grant          (grant),
        .request_bundle (request_bundle),
        .head_flit      (head_flit),
        .occupancy      (occupancy),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_flit(input int x, input int y);
        logic [XW-1:0] fx;
        logic [YW-1:0] fy;
        fx = XW'(x);
        fy = YW'(y);
        return {fx, fy, 32'($urandom)};
    endfunction

    function automatic logic [2:0] exp_bundle();
        logic [FW-1:0] h;
        if (exp_q.size() == 0) return 3'b000;
        h = exp_q[0];
        return {h[FW-1 -: XW] == 3'd2, h[FW-XW-1 -: YW] == 3'd1, 1'b1};
    endfunction

    // Called at a negedge: drive one cycle, update the model, check after the edge.
    task automatic step(input string tag, input logic v, input logic [FW-1:0] f, input logic g);
        logic          pop;
        logic [FW-1:0] hexp;
        in_valid = v;
        in_flit  = f;
        grant    = g;
        pop = g && (exp_q.size() != 0);
        if (pop) begin
            check_eq({tag, "_popdata"}, 64'(head_flit), 64'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        if (v) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(f);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        grant    = 1'b0;
        if (credit_out) n_credits++;
        hexp = (exp_q.size() != 0) ? exp_q[0] : '0;
        check_eq({tag, "_credit"}, 64'(credit_out), 64'(pop));
        check_eq({tag, "_occ"}, 64'(occupancy), 64'(exp_q.size()));
        check_eq({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
        check_eq({tag, "_bundle"}, 64'(request_bundle), 64'(exp_bundle()));
        check_eq({tag, "_head"}, 64'(head_flit), 64'(hexp));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_bundle"}, 64'(request_bundle), 64'(3'b000));
        check_eq({tag, "_occ"}, 64'(occupancy), 64'd0);
        check_eq({tag, "_ovf"}, 64'(overflow), 64'd0);
        check_eq({tag, "_credit"}, 64'(credit_out), 64'd0);
        check_eq({tag, "_head"}, 64'(head_flit), 64'd0);
    endtask

    initial begin
        int c0;
        n_checks  = 0;
        n_errors  = 0;
        n_credits = 0;
        m_ovf     = 1'b0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_flit   = '0;
        grant     = 1'b0;

        // Reset behaviour
        repeat (3) @(negedge clk);
        check_reset_state("rst_hold");
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("rst_rel");
        step("first", 1'b1, mk_flit(2, 1), 1'b0);
        step("first_pop", 1'b0, '0, 1'b1);

        // Destination decode, back-to-back pops
        step("dec_a", 1'b1, mk_flit(2, 3), 1'b0);
        step("dec_b", 1'b1, mk_flit(0, 1), 1'b0);
        step("dec_c", 1'b1, mk_flit(5, 5), 1'b0);
        repeat (3) step("dec_pop", 1'b0, '0, 1'b1);

        // Full plus simultaneous push and grant
        for (int i = 0; i < DEPTH; i++)
            step("fill", 1'b1, mk_flit($urandom_range(0, 7), $urandom_range(0, 7)), 1'b0);
        step("full_pp", 1'b1, mk_flit(2, 1), 1'b1);

        // Overflow: drop, sticky, exact drain
        step("ovf_push", 1'b1, mk_flit(7, 7), 1'b0);
        step("ovf_idle", 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1);
        step("drain_extra", 1'b0, '0, 1'b1);

        // Empty grant and empty push+grant
        step("empty_g", 1'b0, '0, 1'b1);
        step("empty_pg", 1'b1, mk_flit(2, 0), 1'b1);
        step("empty_pg_pop", 1'b0, '0, 1'b1);

        // Stream 10 flits with continuous grant, wrapping the pointers
        c0 = n_credits;
        for (int i = 0; i < 10; i++)
            step("stream", 1'b1, mk_flit($urandom_range(0, 7), $urandom_range(0, 7)), 1'b1);
        for (int i = 0; i < 3 && exp_q.size() != 0; i++) step("stream_tail", 1'b0, '0, 1'b1);
        check_eq("stream_credits", 64'(n_credits - c0), 64'd10);

        // Mid-operation asynchronous reset with 3 flits stored
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, mk_flit(2, 1), 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("mid_rst");
        exp_q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step("post_rst", 1'b0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
